instr_fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS core. It holds the program counter and issues word reads to the instruction memory, which has a fixed one-cycle read latency. Fetched words go into a small prefetch queue that feeds decode over a valid/ready handshake. Branch/jump redirects and exception entry flush the queue and discard stale in-flight reads using an epoch bit.

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, one-cycle-latency imem reads and a small prefetch
// queue to decode. An epoch bit drops responses that belong to a flushed stream.
module instr_fetch_unit #(
  parameter logic [31:0] InstrOffset      = 32'h00400000,
  parameter int          InstrAddrWidth   = 13,
  parameter logic [31:0] ExceptionAddress = 32'h00000004,
  parameter int          QueueDepth       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [InstrAddrWidth-1:0] imem_addr,
  input  logic [31:0]               imem_rdata,
  input  logic                      redirect,
  input  logic [31:0]               redirect_target,
  input  logic                      exception,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic [31:0]               out_pc,
  output logic                      out_fault
);

  localparam int PtrW = $clog2(QueueDepth);
  localparam int CntW = PtrW + 1;

  logic [31:0]     pc_reg, pc_next;
  logic            epoch_reg, epoch_next;
  logic            halted_reg, halted_next;
  logic            inflight_valid_reg, inflight_valid_next;
  logic            inflight_epoch_reg, inflight_epoch_next;
  logic [31:0]     inflight_pc_reg, inflight_pc_next;
  logic [PtrW-1:0] head_reg, head_next;
  logic [PtrW-1:0] tail_reg, tail_next;
  logic [CntW-1:0] count_reg, count_next;

  logic [31:0] q_instr_reg [QueueDepth];
  logic [31:0] q_pc_reg    [QueueDepth];
  logic        q_fault_reg [QueueDepth];

  logic            pop;
  logic            flush;
  logic [CntW-1:0] occupancy;
  logic            credit_ok;
  logic            can_issue;
  logic            issue;
  logic            misalign_push;
  logic            resp_push;
  logic            push;
  logic [31:0]     push_instr;
  logic [31:0]     push_pc;
  logic            push_fault;

  assign out_valid = (count_reg != '0);
  assign out_instr = out_valid ? q_instr_reg[head_reg] : 32'h0;
  assign out_pc    = out_valid ? q_pc_reg[head_reg]    : 32'h0;
  assign out_fault = out_valid & q_fault_reg[head_reg];

  assign pop   = out_valid & out_ready;
  assign flush = exception | redirect;

  // Slots already promised: queued entries plus the read still in flight.
  assign occupancy = count_reg + CntW'(inflight_valid_reg) - CntW'(pop);
  assign credit_ok = occupancy < CntW'(QueueDepth);

  assign can_issue     = credit_ok & ~halted_reg & ~flush;
  assign issue         = can_issue & (pc_reg[1:0] == 2'b00);
  assign misalign_push = can_issue & (pc_reg[1:0] != 2'b00);
  assign resp_push     = inflight_valid_reg & (inflight_epoch_reg == epoch_reg) & ~flush;
  assign push          = resp_push | misalign_push;

  assign push_instr = misalign_push ? 32'h0  : imem_rdata;
  assign push_pc    = misalign_push ? pc_reg : inflight_pc_reg;
  assign push_fault = misalign_push;

  assign imem_req  = issue & ~reset;
  assign imem_addr = pc_reg[InstrAddrWidth+1:2];

  always_comb begin
    pc_next             = pc_reg;
    epoch_next          = epoch_reg;
    halted_next         = halted_reg;
    inflight_valid_next = issue;
    inflight_epoch_next = inflight_epoch_reg;
    inflight_pc_next    = inflight_pc_reg;
    head_next           = head_reg;
    tail_next           = tail_reg;
    count_next          = count_reg;

    if (issue) begin
      inflight_epoch_next = epoch_reg;
      inflight_pc_next    = pc_reg;
      pc_next             = pc_reg + 32'd4;
    end
    if (misalign_push) begin
      halted_next = 1'b1;
    end

    if (flush) begin
      pc_next     = exception ? ExceptionAddress : redirect_target;
      epoch_next  = ~epoch_reg;
      halted_next = 1'b0;
      head_next   = '0;
      tail_next   = '0;
      count_next  = '0;
    end else begin
      if (push) tail_next = tail_reg + PtrW'(1);
      if (pop)  head_next = head_reg + PtrW'(1);
      count_next = count_reg + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg             <= InstrOffset;
      epoch_reg          <= 1'b0;
      halted_reg         <= 1'b0;
      inflight_valid_reg <= 1'b0;
      inflight_epoch_reg <= 1'b0;
      inflight_pc_reg    <= 32'h0;
      head_reg           <= '0;
      tail_reg           <= '0;
      count_reg          <= '0;
    end else begin
      pc_reg             <= pc_next;
      epoch_reg          <= epoch_next;
      halted_reg         <= halted_next;
      inflight_valid_reg <= inflight_valid_next;
      inflight_epoch_reg <= inflight_epoch_next;
      inflight_pc_reg    <= inflight_pc_next;
      head_reg           <= head_next;
      tail_reg           <= tail_next;
      count_reg          <= count_next;
    end
  end

  // Entry payload needs no reset: out_valid masks it until written.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      q_instr_reg[tail_reg] <= push_instr;
      q_pc_reg[tail_reg]    <= push_pc;
      q_fault_reg[tail_reg] <= push_fault;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit: a stream-level model predicts
// every accepted decode entry, plus cycle-exact checks on latency and flush timing.
module tb_instr_fetch_unit;

  localparam logic [31:0] InstrOffset = 32'h00400000;
  localparam int          AW          = 13;
  localparam logic [31:0] ExcAddr     = 32'h00000004;
  localparam int          Depth       = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic          redirect;
  logic [31:0]   redirect_target;
  logic          exception;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          out_fault;

  int total = 0;
  int bad   = 0;

  // Reference model state: next PC decode should see, and whether fetch is parked.
  logic [31:0] exp_pc   = InstrOffset;
  logic        m_halted = 1'b0;
  int          n_pop    = 0;

  instr_fetch_unit #(
    .InstrOffset(InstrOffset), .InstrAddrWidth(AW),
    .ExceptionAddress(ExcAddr), .QueueDepth(Depth)
  ) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_target(redirect_target),
    .exception(exception), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory: word i holds 0x20000000+i, one-cycle read latency.
  always @(posedge clk) imem_rdata <= 32'h20000000 + 32'(imem_addr);

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h20000000 + ((pc >> 2) & 32'h00001FFF);
  endfunction

  function automatic logic [31:0] idx_of(input logic [31:0] pc);
    return (pc >> 2) & 32'h00001FFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model observes the cycle at the falling edge, then we move past the rising edge.
  task automatic step();
    logic f;
    @(negedge clk);
    if (!reset) begin
      if (m_halted) chk("req_while_halted", {31'b0, imem_req}, 32'd0);
      if (out_valid && out_ready) begin
        if (m_halted) begin
          chk("pop_after_fault", {31'b0, out_valid}, 32'd0);
        end else begin
          f = (exp_pc[1:0] != 2'b00);
          chk("pop_pc", out_pc, exp_pc);
          chk("pop_instr", out_instr, f ? 32'h0 : word_at(exp_pc));
          chk("pop_fault", {31'b0, out_fault}, {31'b0, f});
          $display("pop pc=%h instr=%h fault=%0d", out_pc, out_instr, out_fault);
          n_pop++;
          if (f) m_halted = 1'b1;
          else   exp_pc   = exp_pc + 32'd4;
        end
      end
    end
    if (reset) begin
      exp_pc = InstrOffset; m_halted = 1'b0;
    end else if (exception) begin
      exp_pc = ExcAddr; m_halted = 1'b0;
    end else if (redirect) begin
      exp_pc = redirect_target; m_halted = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] held_pc;
  int          start_pops;

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_target = 32'h0;
    exception = 1'b0; out_ready = 1'b1;
    step(); step();
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_fault", {31'b0, out_fault}, 32'd0);
    step();

    // Fill after reset release: first request now, head valid two cycles later.
    reset = 1'b0; #1;
    chk("fill_req", {31'b0, imem_req}, 32'd1);
    chk("fill_addr", 32'(imem_addr), idx_of(InstrOffset));
    chk("fill_valid_c0", {31'b0, out_valid}, 32'd0);
    step(); #1;
    chk("fill_valid_c1", {31'b0, out_valid}, 32'd0);
    step(); #1;
    chk("fill_valid_c2", {31'b0, out_valid}, 32'd1);
    chk("fill_pc", out_pc, InstrOffset);
    chk("fill_instr", out_instr, 32'h20000000);
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
    end

    // Backpressure for 5 cycles.
    out_ready = 1'b0; #1;
    held_pc = out_pc;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("bp_head_stable", out_pc, held_pc);
      if (i >= 1) chk("bp_req_low", {31'b0, imem_req}, 32'd0);
    end
    out_ready = 1'b1; #1;
    chk("bp_resume_req", {31'b0, imem_req}, 32'd1);
    chk("bp_resume_addr", 32'(imem_addr), idx_of(held_pc + 32'(4 * Depth)));
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      chk("bp_no_gap", {31'b0, out_valid}, 32'd1);
    end

    // Redirect while a read is in flight.
    redirect = 1'b1; redirect_target = 32'h00400100;
    step(); redirect = 1'b0; #1;
    chk("redir_flush_r1", {31'b0, out_valid}, 32'd0);
    chk("redir_req_r1", {31'b0, imem_req}, 32'd1);
    chk("redir_addr_r1", 32'(imem_addr), 32'h40);
    step(); #1;
    chk("redir_valid_r2", {31'b0, out_valid}, 32'd0);
    step(); #1;
    chk("redir_valid_r3", {31'b0, out_valid}, 32'd1);
    chk("redir_pc_r3", out_pc, 32'h00400100);
    for (int i = 0; i < 4; i++) step();

    // Exception and redirect together: exception wins.
    exception = 1'b1; redirect = 1'b1; redirect_target = 32'h00400200;
    step(); exception = 1'b0; redirect = 1'b0; #1;
    chk("exc_req", {31'b0, imem_req}, 32'd1);
    chk("exc_addr", 32'(imem_addr), 32'd1);
    step(); step(); #1;
    chk("exc_pc", out_pc, ExcAddr);
    chk("exc_instr", out_instr, 32'h20000001);
    for (int i = 0; i < 4; i++) step();

    // Misaligned target produces one fault entry and parks fetch.
    redirect = 1'b1; redirect_target = 32'h00400102;
    step(); redirect = 1'b0; #1;
    chk("mis_no_req", {31'b0, imem_req}, 32'd0);
    step(); #1;
    chk("mis_valid", {31'b0, out_valid}, 32'd1);
    chk("mis_fault", {31'b0, out_fault}, 32'd1);
    chk("mis_pc", out_pc, 32'h00400102);
    chk("mis_instr", out_instr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk("mis_parked_req", {31'b0, imem_req}, 32'd0);
      chk("mis_parked_valid", {31'b0, out_valid}, 32'd0);
    end
    redirect = 1'b1; redirect_target = 32'h00400300;
    step(); redirect = 1'b0; #1;
    chk("mis_resume_req", {31'b0, imem_req}, 32'd1);
    chk("mis_resume_addr", 32'(imem_addr), 32'hC0);
    for (int i = 0; i < 6; i++) step();

    // Reset pulse mid-stream.
    reset = 1'b1;
    step(); reset = 1'b0; #1;
    chk("rp_valid_x1", {31'b0, out_valid}, 32'd0);
    chk("rp_req_x1", {31'b0, imem_req}, 32'd1);
    chk("rp_addr_x1", 32'(imem_addr), idx_of(InstrOffset));
    step(); #1;
    chk("rp_valid_x2", {31'b0, out_valid}, 32'd0);
    step(); #1;
    chk("rp_pc_x3", out_pc, InstrOffset);
    chk("rp_instr_x3", out_instr, 32'h20000000);

    // Randomized traffic: backpressure, redirects (some misaligned), exceptions.
    start_pops = n_pop;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect  = ($urandom_range(0, 15) == 0);
      exception = ($urandom_range(0, 63) == 0);
      redirect_target = InstrOffset + (32'($urandom_range(0, 1023)) << 2);
      if ($urandom_range(0, 7) == 0) redirect_target = redirect_target | 32'($urandom_range(1, 3));
      step();
    end
    redirect = 1'b0; exception = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rand_progress", {31'b0, (n_pop - start_pops) >= 150}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
